// File: rtl/mul_sched_pkg.sv
// Shared types for the MUL scheduler: default widths and the in-flight slot record.
package mul_sched_pkg;
  localparam int MUL_LAT_D = 4;
  localparam int REG_W_D   = 5;

  // Slot rd is sized to the default register width; narrower REG_W indices are zero-extended.
  typedef logic [REG_W_D-1:0] rd_t;

  typedef struct packed {
    logic valid;
    rd_t  rd;
  } slot_t;
endpackage

// File: rtl/mul_inflight_tracker.sv
// Fixed-latency tracker: one slot per multiplier stage, shifting every cycle, plus a live count.
module mul_inflight_tracker
  import mul_sched_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  input  rd_t                   push_rd,
  output slot_t [MUL_LAT:1]     slots,
  output logic  [2:0]           inflight
);

  logic [2:0] cnt_nxt;

  // Count of slots that will be valid after the next shift (S4 drops out, push enters S1).
  always_comb begin
    cnt_nxt = 3'(push_valid);
    for (int i = 1; i < MUL_LAT; i++)
      cnt_nxt = cnt_nxt + 3'(slots[i].valid);
  end

  // Unconditional shift; rd is kept zero in empty slots so downstream sees a clean index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots    <= '0;
      inflight <= '0;
    end else begin
      slots[1].valid <= push_valid;
      slots[1].rd    <= push_valid ? push_rd : '0;
      for (int i = 2; i <= MUL_LAT; i++)
        slots[i] <= slots[i-1];
      inflight <= cnt_nxt;
    end
  end

endmodule

// File: rtl/mul_scheduler.sv
// Issue-side scheduler for a fixed-latency multiplier: RAW/WAW/writeback-port stalls and S4 bypass.
module mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_D,
  parameter int REG_W   = REG_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_is_mul,
  input  logic [REG_W-1:0] issue_rs1,
  input  logic [REG_W-1:0] issue_rs2,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_uses_rs2,
  input  logic             issue_writes_rd,
  output logic             stall,
  output logic             mul_go,
  output logic             wb_en,
  output logic [REG_W-1:0] wb_rd,
  output logic             fwd_rs1,
  output logic             fwd_rs2,
  output logic [2:0]       inflight
);

  slot_t [MUL_LAT:1] slots;
  slot_t             s4;
  rd_t               rs1_x, rs2_x, rd_x;
  logic              hit_rs1, hit_rs2, hit_rd;
  logic              raw, waw, wb_conflict, accept, push_valid;

  assign rs1_x = rd_t'(issue_rs1);
  assign rs2_x = rd_t'(issue_rs2);
  assign rd_x  = rd_t'(issue_rd);
  assign s4    = slots[MUL_LAT];

  // Matches against results not yet available (S1..S3); these cannot be bypassed.
  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    hit_rd  = 1'b0;
    for (int i = 1; i < MUL_LAT; i++) begin
      if (slots[i].valid && slots[i].rd == rs1_x) hit_rs1 = 1'b1;
      if (slots[i].valid && slots[i].rd == rs2_x) hit_rs2 = 1'b1;
      if (slots[i].valid && slots[i].rd == rd_x)  hit_rd  = 1'b1;
    end
  end

  // Stall reasons; a MUL never collides on the writeback port since its slot is reserved.
  always_comb begin
    raw         = ((rs1_x != '0) && hit_rs1) ||
                  (issue_uses_rs2 && (rs2_x != '0) && hit_rs2);
    waw         = issue_writes_rd && (rd_x != '0) && hit_rd;
    wb_conflict = !issue_is_mul && issue_writes_rd && slots[MUL_LAT-1].valid;
    stall       = issue_valid && (raw || waw || wb_conflict);
    accept      = issue_valid && !stall;
    mul_go      = accept && issue_is_mul;
    push_valid  = mul_go && (rd_x != '0);
    fwd_rs1     = (rs1_x != '0) && s4.valid && (s4.rd == rs1_x) && !hit_rs1;
    fwd_rs2     = (rs2_x != '0) && s4.valid && (s4.rd == rs2_x) && !hit_rs2;
  end

  assign wb_en = s4.valid;
  assign wb_rd = s4.rd[REG_W-1:0];

  mul_inflight_tracker #(.MUL_LAT(MUL_LAT)) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_rd    (rd_x),
    .slots      (slots),
    .inflight   (inflight)
  );

endmodule

// File: tb/tb_mul_scheduler.sv
// Bench: directed scenarios plus random traffic, checked each cycle against a
// completion-time list of accepted multiplies.
module tb_mul_scheduler;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_is_mul, issue_uses_rs2, issue_writes_rd;
  logic [4:0] issue_rs1, issue_rs2, issue_rd;
  logic       stall, mul_go, wb_en, fwd_rs1, fwd_rs2;
  logic [4:0] wb_rd;
  logic [2:0] inflight;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int q_rd[$];
  int q_done[$];
  bit exp_acc;
  int last_stall, last_go, last_wb_en, last_wb_rd, last_fwd1, last_infl;

  mul_scheduler dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_is_mul(issue_is_mul),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_uses_rs2(issue_uses_rs2), .issue_writes_rd(issue_writes_rd),
    .stall(stall), .mul_go(mul_go), .wb_en(wb_en), .wb_rd(wb_rd),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Result of register r still 1..3 cycles away from writeback.
  function automatic bit busy(input int r);
    if (r == 0) return 1'b0;
    foreach (q_rd[i])
      if (q_rd[i] == r && q_done[i] - cyc >= 1 && q_done[i] - cyc <= 3) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit wb_next_cycle();
    foreach (q_done[i]) if (q_done[i] - cyc == 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int wb_now();
    foreach (q_done[i]) if (q_done[i] == cyc) return q_rd[i];
    return -1;
  endfunction

  function automatic int pending();
    int n = 0;
    foreach (q_done[i]) if (q_done[i] - cyc >= 0 && q_done[i] - cyc <= 3) n++;
    return n;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    bit e_stall, e_f1, e_f2;
    int w;
    e_stall = issue_valid && (busy(int'(issue_rs1)) ||
              (issue_uses_rs2 && busy(int'(issue_rs2))) ||
              (issue_writes_rd && busy(int'(issue_rd))) ||
              (!issue_is_mul && issue_writes_rd && wb_next_cycle()));
    exp_acc = issue_valid && !e_stall;
    w = wb_now();
    e_f1 = issue_rs1 != 0 && w == int'(issue_rs1) && !busy(int'(issue_rs1));
    e_f2 = issue_rs2 != 0 && w == int'(issue_rs2) && !busy(int'(issue_rs2));
    check("stall", int'(stall), int'(e_stall));
    check("mul_go", int'(mul_go), int'(exp_acc && issue_is_mul));
    check("wb_en", int'(wb_en), int'(w >= 0));
    if (w >= 0) check("wb_rd", int'(wb_rd), w);
    check("fwd_rs1", int'(fwd_rs1), int'(e_f1));
    check("fwd_rs2", int'(fwd_rs2), int'(e_f2));
    check("inflight", int'(inflight), pending());
    last_stall = int'(stall); last_go = int'(mul_go); last_wb_en = int'(wb_en);
    last_wb_rd = int'(wb_rd); last_fwd1 = int'(fwd_rs1); last_infl = int'(inflight);
  endtask

  task automatic step(input bit v, input bit m, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] d, input bit u2, input bit w);
    issue_valid = v; issue_is_mul = m; issue_rs1 = r1; issue_rs2 = r2;
    issue_rd = d; issue_uses_rs2 = u2; issue_writes_rd = w;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    if (exp_acc && m && d != 0) begin
      q_rd.push_back(int'(d));
      q_done.push_back(cyc + LAT);
    end
    cyc++;
    for (int i = q_rd.size() - 1; i >= 0; i--)
      if (q_done[i] < cyc) begin q_rd.delete(i); q_done.delete(i); end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    issue_valid = 1'b1; issue_is_mul = 1'b0; issue_writes_rd = 1'b1;
    issue_rs1 = 5'd1; issue_rs2 = 5'd2; issue_rd = 5'd3; issue_uses_rs2 = 1'b1;
    #2;
    check("rst_wb_en", int'(wb_en), 0);
    check("rst_wb_rd", int'(wb_rd), 0);
    check("rst_inflight", int'(inflight), 0);
    check("rst_stall", int'(stall), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Single MUL rd=5, accepted on the first edge after reset release.
    step(1, 1, 5'd0, 5'd0, 5'd5, 0, 1);
    check("single_go", last_go, 1);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      check("single_infl", last_infl, 1);
      check("single_wb_en", last_wb_en, int'(k == 4));
      if (k == 4) check("single_wb_rd", last_wb_rd, 5);
    end
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    check("single_infl_end", last_infl, 0);

    // RAW on MUL rd=7: stalled three cycles, then forwarded.
    step(1, 1, 5'd0, 5'd0, 5'd7, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      step(1, 0, 5'd7, 5'd0, 5'd10, 0, 1);
      check("raw_stall", last_stall, 1);
    end
    step(1, 0, 5'd7, 5'd0, 5'd10, 0, 1);
    check("raw_accept", last_stall, 0);
    check("raw_fwd", last_fwd1, 1);
    idle(4);

    // Writeback-port conflict: ADD writing rd=9 while the MUL sits in S3.
    step(1, 1, 5'd0, 5'd0, 5'd3, 0, 1);
    idle(2);
    step(1, 0, 5'd1, 5'd2, 5'd9, 1, 1);
    check("wbport_stall", last_stall, 1);
    step(1, 0, 5'd1, 5'd2, 5'd9, 1, 1);
    check("wbport_accept", last_stall, 0);
    idle(4);

    // Four back-to-back MULs.
    for (int k = 1; k <= 4; k++) begin
      step(1, 1, 5'd0, 5'd0, 5'(k), 0, 1);
      check("b2b_stall", last_stall, 0);
    end
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      if (k == 1) check("b2b_infl4", last_infl, 4);
      check("b2b_wb_rd", last_wb_rd, k);
    end
    idle(2);

    // MUL to r0 leaves nothing behind; reading r0 never stalls.
    step(1, 1, 5'd0, 5'd0, 5'd0, 0, 1);
    check("r0_go", last_go, 1);
    step(1, 0, 5'd0, 5'd0, 5'd0, 1, 1);
    check("r0_stall", last_stall, 0);
    idle(3);
    check("r0_wb_en", last_wb_en, 0);

    // Asynchronous reset with two MULs in flight.
    step(1, 1, 5'd0, 5'd0, 5'd6, 0, 1);
    step(1, 1, 5'd0, 5'd0, 5'd8, 0, 1);
    issue_valid = 1'b0; issue_is_mul = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_infl", int'(inflight), 0);
    check("arst_wb_en", int'(wb_en), 0);
    q_rd.delete(); q_done.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      check("arst_no_wb", last_wb_en, 0);
    end

    // Random traffic over a small register set to provoke hazards.
    for (int n = 0; n < 400; n++)
      step($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
           5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
           $urandom_range(1, 0) == 1, $urandom_range(3, 0) != 0);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mul_scheduler.md
MUL_SCHEDULER -- requirements
Module: mul_scheduler

Interface
REQ-001 Parameter MUL_LAT, default 4, multiplier pipeline depth in cycles, fixed at 4 for this release.
REQ-002 Parameter REG_W, default 5, register-index width.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 issue_valid  input  1  decode presents an instruction this cycle.
REQ-006 issue_is_mul  input  1  presented instruction is MUL.
REQ-007 issue_rs1, issue_rs2, issue_rd  input  REG_W each  source and destination indices.
REQ-008 issue_uses_rs2, issue_writes_rd  input  1 each  operand/destination usage flags.
REQ-009 stall  output  1  holds decode; instruction not accepted this cycle.
REQ-010 mul_go  output  1  drive multiplier select to MUL this cycle.
REQ-011 wb_en  output  1  multiplier result writes back this cycle.
REQ-012 wb_rd  output  REG_W  destination of multiplier writeback.
REQ-013 fwd_rs1, fwd_rs2  output  1 each  select multiplier result as operand bypass.
REQ-014 inflight  output  3  count of multiplies in flight, 0..4.

Function
REQ-015 Accept = issue_valid & ~stall; a MUL accepted in cycle t SHALL have its result valid in cycle t+4.
REQ-016 Tracker SHALL hold slots S1..S4 (valid, rd); accepted MUL enters S1 at the next edge; every slot shifts one position per cycle unconditionally; S4 shifts out.
REQ-017 wb_en SHALL equal S4.valid and wb_rd SHALL equal S4.rd, with slots whose rd=0 stored as invalid.
REQ-018 mul_go SHALL equal accept & issue_is_mul.
REQ-019 RAW: stall SHALL assert when issue_valid and rs1 (or rs2 with issue_uses_rs2) is nonzero and matches rd of a valid S1, S2 or S3.
REQ-020 Bypass: fwd_rs1/fwd_rs2 SHALL assert when the source is nonzero, matches valid S4.rd, and no S1-S3 match exists; the youngest match wins.
REQ-021 Writeback port: non-MUL results write back at t+1; stall SHALL assert for a non-MUL with issue_writes_rd when S3.valid, because MUL has writeback priority.
REQ-022 WAW: stall SHALL assert for any writing instruction whose nonzero rd matches a valid S1-S3 rd.
REQ-023 A MUL SHALL NOT be stalled by the writeback rule because its completion slot is unique by construction.
REQ-024 inflight SHALL equal the number of valid S1-S4 slots and SHALL never exceed 4.
REQ-025 stall SHALL be combinational on inputs and slot state; all other outputs SHALL be from registers, except mul_go and fwd_*, which are combinational.
REQ-026 Back-to-back MULs (one per cycle) SHALL be accepted without stall when free of hazards.
REQ-027 Simultaneous S4 writeback and new MUL accept SHALL both occur in the same cycle.

Reset
REQ-028 When rst=0, all slots SHALL clear asynchronously; wb_en=0, wb_rd=0, inflight=0, stall=0.
REQ-029 Reset mid-operation SHALL discard in-flight MULs; no wb_en SHALL follow release.
REQ-030 First accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-031 Shared package mul_sched_pkg SHALL hold MUL_LAT, REG_W defaults, and the slot struct (valid, rd).
REQ-032 One sub-module, mul_inflight_tracker (shift of slots plus count), SHALL be instantiated; hazard and bypass logic SHALL stay in the top.
REQ-033 Target size SHALL be 120-400 RTL lines.

Verification
REQ-034 Single MUL rd=5 at t0 -> mul_go at t0; wb_en=1, wb_rd=5 at t0+4 only; inflight 1,1,1,1,0.
REQ-035 MUL rd=7 at t0, then ADD rs1=7 -> stall for t0+1..t0+3; fwd_rs1=1 and accept at t0+4.
REQ-036 MUL rd=3 at t0, ADD rd=9 at t0+3 -> stall at t0+3 (S3 valid), accept at t0+4.
REQ-037 Four MULs rd=1..4 on consecutive cycles -> no stall; inflight reaches 4; wb_rd=1,2,3,4 on cycles t0+4..t0+7.
REQ-038 MUL rd=0 -> no wb_en, no hazard; ADD rs1=0 is never stalled.
REQ-039 Two MULs in flight, rst=0 asynchronously mid-cycle -> inflight=0, wb_en=0 immediately, none after release.
